// File: rtl/sd_data_rx_host_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sd_data_rx_host_pkg
// Purpose  : Shared definitions for the SD data-path receive host: bus width
//            define, FSM state encodings, CRC16 polynomial and a one-bit
//            CRC16 update helper.
// Macros   : SD_BUS_W (DAT bus width, 4). SD_RX_1BIT_MODE_EN is consumed by
//            sd_data_rx_host, not here.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef SD_BUS_W
`define SD_BUS_W 4
`endif

package sd_data_rx_host_pkg;

    // CRC16 generator x^16 + x^12 + x^5 + 1.
    localparam logic [15:0] C_CRC16_POLY = 16'h1021;

    // Receive FSM state encodings.
    localparam logic [2:0] C_ST_IDLE       = 3'd0;
    localparam logic [2:0] C_ST_WAIT_START = 3'd1;
    localparam logic [2:0] C_ST_DATA       = 3'd2;
    localparam logic [2:0] C_ST_CRC        = 3'd3;
    localparam logic [2:0] C_ST_END        = 3'd4;
    localparam logic [2:0] C_ST_DONE       = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE       = C_ST_IDLE,
        S_WAIT_START = C_ST_WAIT_START,
        S_DATA       = C_ST_DATA,
        S_CRC        = C_ST_CRC,
        S_END        = C_ST_END,
        S_DONE       = C_ST_DONE
    } state_t;

    // One MSB-first serial CRC16 step.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                               input logic        din);
        logic w_fb;
        w_fb = din ^ crc[15];
        return {crc[14:0], 1'b0} ^ (w_fb ? C_CRC16_POLY : 16'h0000);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sd_crc_16.sv
`default_nettype none
// ============================================================================
// Module   : sd_crc_16
// Purpose  : Serial CRC16 (x^16+x^12+x^5+1, init 0, MSB-first) for one DAT
//            lane.
// Ports    : clk    - SD clock
//            rst    - asynchronous active-low reset
//            i_clr  - synchronous clear to 0 (priority over i_en)
//            i_en   - shift i_din into the CRC this cycle
//            i_din  - serial data bit
//            o_crc  - current CRC register
// Revision : 1.0 - initial release
// ============================================================================
module sd_crc_16
    import sd_data_rx_host_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic        i_din,
    output logic [15:0] o_crc
);

    logic [15:0] r_crc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_crc <= 16'h0000;
        end else if (i_clr) begin
            r_crc <= 16'h0000;
        end else if (i_en) begin
            r_crc <= crc16_step(r_crc, i_din);
        end
    end

    assign o_crc = r_crc;

endmodule

`default_nettype wire

// File: rtl/sd_data_rx_host.sv
`default_nettype none
// ============================================================================
// Module   : sd_data_rx_host
// Purpose  : SD data-path receive host (sd_clk domain). Waits for the start
//            bit, streams one block into the RX FIFO as nibbles, checks the
//            per-lane CRC16 and the end bit, and reports status.
// Ports    : clk, rst (async active-low), start, dat_in[3:0], full,
//            bus_4bit (only with SD_RX_1BIT_MODE_EN),
//            dat_o[3:0], wr, busy, done, crc_ok, overrun, timeout.
// Params   : BLK_BYTES - bytes per block (even, 2..2048)
//            TIMEOUT   - clk cycles to wait for the start bit
// Macros   : SD_RX_1BIT_MODE_EN - adds bus_4bit; 1-bit DAT0 mode when 0.
// Revision : 1.0 - initial release
// ============================================================================
module sd_data_rx_host
    import sd_data_rx_host_pkg::*;
#(
    parameter int BLK_BYTES = 512,
    parameter int TIMEOUT   = 65535
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [`SD_BUS_W-1:0] dat_in,
    input  logic                 full,
`ifdef SD_RX_1BIT_MODE_EN
    input  logic                 bus_4bit,
`endif
    output logic [`SD_BUS_W-1:0] dat_o,
    output logic                 wr,
    output logic                 busy,
    output logic                 done,
    output logic                 crc_ok,
    output logic                 overrun,
    output logic                 timeout
);

    localparam int              C_WAIT_W   = $clog2(TIMEOUT + 1);
    localparam logic [11:0]     C_LAST_NIB = 12'(BLK_BYTES * 2 - 1);
    localparam logic [C_WAIT_W-1:0] C_TMO  = C_WAIT_W'(TIMEOUT);

    state_t                 r_state;
    logic [C_WAIT_W-1:0]    r_wait_cnt;
    logic [11:0]            r_nib_cnt;
    logic [3:0]             r_crc_cnt;
    logic                   r_match;
    logic [`SD_BUS_W-1:0]   r_dat_o;
    logic                   r_wr;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_crc_ok;
    logic                   r_overrun;
    logic                   r_timeout;
`ifdef SD_RX_1BIT_MODE_EN
    logic                   r_mode4;
    logic [1:0]             r_bit_cnt;
    logic [2:0]             r_sh;
`endif

    logic [`SD_BUS_W-1:0]   w_mask;
    logic                   w_nib_rdy;
    logic [`SD_BUS_W-1:0]   w_nib;

    // Active lanes and nibble assembly. In 1-bit mode a nibble is complete
    // on every fourth DAT0 bit, packed MSB-first.
    always_comb begin
        w_mask    = '1;
        w_nib_rdy = 1'b1;
        w_nib     = dat_in;
`ifdef SD_RX_1BIT_MODE_EN
        if (!r_mode4) begin
            w_mask    = {{(`SD_BUS_W-1){1'b0}}, 1'b1};
            w_nib_rdy = (r_bit_cnt == 2'd3);
            w_nib     = {r_sh, dat_in[0]};
        end
`endif
    end

    // ------------------------------------------------------------------
    // Per-lane CRC16. The generators keep running through the CRC field:
    // when each received CRC bit equals the register MSB the feedback is
    // zero, so the register simply shifts and a good block leaves zero.
    // ------------------------------------------------------------------
    logic [15:0]          w_crc [`SD_BUS_W];
    logic [`SD_BUS_W-1:0] w_crc_msb;
    logic [`SD_BUS_W-1:0] w_crc_zero;
    logic                 w_crc_clr;
    logic                 w_crc_run;

    assign w_crc_clr = (r_state == S_IDLE);
    assign w_crc_run = (r_state == S_DATA) || (r_state == S_CRC);

    generate
        for (genvar g = 0; g < `SD_BUS_W; g++) begin : g_lane
            sd_crc_16 u_crc (
                .clk   (clk),
                .rst   (rst),
                .i_clr (w_crc_clr),
                .i_en  (w_crc_run & w_mask[g]),
                .i_din (dat_in[g]),
                .o_crc (w_crc[g])
            );
            assign w_crc_msb[g]  = w_crc[g][15];
            assign w_crc_zero[g] = (w_crc[g] == 16'h0000);
        end
    endgenerate

    logic w_start_bit;
    logic w_end_good;
    logic w_crc_mis;
    logic w_rem_zero;

    assign w_start_bit = ((dat_in & w_mask) == '0);
    assign w_end_good  = ((dat_in & w_mask) == w_mask);
    assign w_crc_mis   = |((dat_in ^ w_crc_msb) & w_mask);
    assign w_rem_zero  = &(w_crc_zero | ~w_mask);

    // ------------------------------------------------------------------
    // Receive FSM with registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_nib_cnt  <= 12'd0;
            r_crc_cnt  <= 4'd0;
            r_match    <= 1'b0;
            r_dat_o    <= '0;
            r_wr       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_crc_ok   <= 1'b0;
            r_overrun  <= 1'b0;
            r_timeout  <= 1'b0;
`ifdef SD_RX_1BIT_MODE_EN
            r_mode4    <= 1'b1;
            r_bit_cnt  <= 2'd0;
            r_sh       <= 3'd0;
`endif
        end else begin
            r_wr   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_WAIT_START;
                        r_busy     <= 1'b1;
                        r_overrun  <= 1'b0;
                        r_timeout  <= 1'b0;
                        r_crc_ok   <= 1'b0;
                        r_wait_cnt <= '0;
                        r_nib_cnt  <= 12'd0;
                        r_crc_cnt  <= 4'd0;
                        r_match    <= 1'b1;
`ifdef SD_RX_1BIT_MODE_EN
                        r_mode4    <= bus_4bit;
                        r_bit_cnt  <= 2'd0;
`endif
                    end
                end

                S_WAIT_START: begin
                    if (w_start_bit) begin
                        r_state <= S_DATA;
                    end else if (r_wait_cnt == C_TMO) begin
                        r_timeout <= 1'b1;
                        r_crc_ok  <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end

                S_DATA: begin
`ifdef SD_RX_1BIT_MODE_EN
                    r_bit_cnt <= r_bit_cnt + 2'd1;
                    r_sh      <= {r_sh[1:0], dat_in[0]};
`endif
                    if (w_nib_rdy) begin
                        // The SD clock cannot be stalled: a nibble that meets
                        // a full FIFO is lost and flagged.
                        if (full) begin
                            r_overrun <= 1'b1;
                        end else begin
                            r_wr    <= 1'b1;
                            r_dat_o <= w_nib;
                        end
                        if (r_nib_cnt == C_LAST_NIB) begin
                            r_state <= S_CRC;
                        end else begin
                            r_nib_cnt <= r_nib_cnt + 12'd1;
                        end
                    end
                end

                S_CRC: begin
                    if (w_crc_mis) begin
                        r_match <= 1'b0;
                    end
                    if (r_crc_cnt == 4'd15) begin
                        r_state <= S_END;
                    end
                    r_crc_cnt <= r_crc_cnt + 4'd1;
                end

                S_END: begin
                    r_crc_ok <= r_match & w_rem_zero & w_end_good;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= S_DONE;
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign dat_o   = r_dat_o;
    assign wr      = r_wr;
    assign busy    = r_busy;
    assign done    = r_done;
    assign crc_ok  = r_crc_ok;
    assign overrun = r_overrun;
    assign timeout = r_timeout;

endmodule

`default_nettype wire

// File: doc/sd_data_rx_host.md
Name: sd_data_rx_host

Overview:
- Receive side of the SD data-path serial host, on the SD card clock domain.
- Detects the start bit on the SD DAT lines, passes one data block as a nibble stream into the RX FIFO write port (`dat_o`/`wr`), and checks the per-lane CRC16 and end bit.
- Reports block completion and status to the data master.
- Sits directly upstream of the RX FIFO filler, which drains the FIFO to Wishbone memory.

Parameters:
- BLK_BYTES, 512, bytes per data block (even, 2..2048).
- TIMEOUT, 65535, clk cycles to wait for the start bit before aborting.

Ports:
- clk  in  1  SD clock (sd_clk domain); all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to receive one block; ignored while busy.
- dat_in  in  `SD_BUS_W`  SD DAT[3:0] lines, sampled on every clk.
- full  in  1  RX FIFO full flag.
- dat_o  out  `SD_BUS_W`  nibble to the RX FIFO.
- wr  out  1  RX FIFO write strobe.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at block end.
- crc_ok  out  1  status; valid with done, held until next start.
- overrun  out  1  sticky; a data nibble arrived while full; cleared on start.
- timeout  out  1  sticky; no start bit within TIMEOUT; cleared on start.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs 0; counters and CRC registers 0.
- States: IDLE, WAIT_START, DATA, CRC, END, DONE.
- IDLE:
  - start=1 -> WAIT_START next cycle; busy=1.
  - Clear overrun, timeout, crc_ok, the wait counter and the CRC registers.
- WAIT_START:
  - Start bit is all active lanes sampled 0. Go to DATA next cycle.
  - If the wait counter reaches TIMEOUT first: timeout=1 -> DONE, crc_ok=0.
- DATA:
  - Each cycle, register dat_in into dat_o and assert wr the following cycle (1-cycle latency). Nibble order is preserved: first nibble on the wire is the high nibble of byte 0.
  - Each lane's bit is shifted into its CRC16 (x^16+x^12+x^5+1, init 0, MSB-first).
  - If full=1 in the write cycle: wr forced 0, nibble dropped, overrun=1. Reception continues because the SD clock is not stalled.
  - Nibble counter is 12 bits. After BLK_BYTES*2 nibbles -> CRC.
- CRC:
  - 16 cycles. Each lane's received bit is compared with that lane's CRC register MSB, then the register shifts.
  - Any mismatch clears an internal match flag.
- END:
  - One cycle; all active lanes must read 1.
  - crc_ok = match flag AND end bit good. -> DONE.
- DONE: done=1 for one cycle, busy=0 -> IDLE.
- start during busy: ignored, no side effects.
- rst asserted mid-block: immediate abort to IDLE. No done pulse; the partial FIFO contents are the filler's responsibility (the filler resets the FIFO).

Optional Feature:
- Macro: SD_RX_1BIT_MODE_EN.
- When defined:
  - Extra input `bus_4bit` (1 bit) selects the mode, sampled at start.
  - With `bus_4bit`=0, only DAT0 is used and 4 consecutive DAT0 bits are packed MSB-first into one dat_o nibble.
  - wr asserts once per 4 bits; DATA lasts BLK_BYTES*8 cycles.
  - Only lane 0 CRC and end bit are checked.
- When undefined: no `bus_4bit` port; 4-bit mode only.

Decomposition:
- Shared package/defines:
  - `SD_BUS_W`.
  - State encodings (3-bit, localparams).
  - CRC16 polynomial constant 16'h1021.
- Sub-module: sd_crc_16 (serial 1-bit in, enable, clear, 16-bit crc out), instantiated once per lane (4 instances).

Test Plan (BLK_BYTES=4 unless stated):
- Start, then start bit after 3 cycles, then 8 zero nibbles, 64 zero CRC bits, end 4'hF -> 8 wr pulses with dat_o=0; done 1 cycle after END; crc_ok=1.
- Data 8'hA5 x4, correct per-lane CRCs from reference model -> nibbles A,5,A,5,A,5,A,5 written in order; crc_ok=1. Same block with lane 2 CRC bit 7 flipped -> crc_ok=0.
- Good data and CRC, end bits 4'hE -> crc_ok=0, done still pulses.
- full held high for nibbles 3-4 -> 6 wr pulses, overrun=1, done pulses. Next start clears overrun.
- TIMEOUT=10, DAT held 4'hF -> timeout=1 and done 11 cycles after start; no wr.
- rst low during nibble 5 -> all outputs 0 immediately, no done. After release, a normal block completes with crc_ok=1.
- SD_RX_1BIT_MODE_EN, bus_4bit=0, BLK_BYTES=512, all 0xFF, CRC 16'h7FA1 on DAT0 -> 1024 wr of 4'hF; crc_ok=1.
